alu_wb_stage: RTL and testbench

- Registered writeback stage directly downstream of the combinational ALU.
- Captures the ALU result, zero/neg flags and operation select into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Keeps sticky status flags and a retired-result counter.
- Cross-checks the incoming flags against the result and latches a sticky error if they disagree.

---
 rtl/alu_wb_stage.sv | 147 ++++++++++++++
 tb/tb_alu_wb_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: registered writeback stage behind the combinational ALU.
// A 2-entry skid buffer holds {sel, res, zero, neg} with valid/ready on both
// sides. The stage also keeps sticky status flags, a saturating retire count
// and a sticky error for ALU flags that disagree with the result.
module alu_wb_stage #(
    parameter int DWIDTH = 8,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [1:0]        sel_i,
    input  logic [DWIDTH-1:0] res_i,
    input  logic              zero_i,
    input  logic              neg_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [1:0]        out_sel_o,
    output logic [DWIDTH-1:0] out_res_o,
    output logic              out_zero_o,
    output logic              out_neg_o,
    output logic              sticky_zero_o,
    output logic              sticky_neg_o,
    output logic              flag_err_o,
    input  logic              clr_sticky_i,
    output logic [CNTW-1:0]   count_o
);

    // Entry layout: {sel[1:0], res[DWIDTH-1:0], zero, neg}
    localparam int EW = DWIDTH + 4;

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          state_r;
    logic [EW-1:0]   head_r;
    logic [EW-1:0]   tail_r;
    logic [EW-1:0]   in_entry_s;
    logic            accept_s;
    logic            retire_s;
    logic            sticky_zero_r;
    logic            sticky_neg_r;
    logic            flag_err_r;
    logic [CNTW-1:0] count_r;

    // True when the ALU flags do not match what the result implies.
    function automatic logic flag_mismatch(
        input logic [DWIDTH-1:0] res,
        input logic              zero,
        input logic              neg
    );
        logic exp_zero;
        logic exp_neg;
        exp_zero = (res == {DWIDTH{1'b0}});
        exp_neg  = res[DWIDTH-1];
        flag_mismatch = (zero != exp_zero) || (neg != exp_neg);
    endfunction

    // Ready depends only on the state register and the reset input, never on out_ready_i.
    assign in_ready_o  = reset && (state_r != ST_FULL);
    assign out_valid_o = (state_r != ST_EMPTY);
    assign accept_s    = in_valid_i && in_ready_o;
    assign retire_s    = out_valid_o && out_ready_i;
    assign in_entry_s  = {sel_i, res_i, zero_i, neg_i};

    assign out_sel_o     = head_r[EW-1 -: 2];
    assign out_res_o     = head_r[DWIDTH+1:2];
    assign out_zero_o    = head_r[1];
    assign out_neg_o     = head_r[0];
    assign sticky_zero_o = sticky_zero_r;
    assign sticky_neg_o  = sticky_neg_r;
    assign flag_err_o    = flag_err_r;
    assign count_o       = count_r;

    // Skid-buffer state machine: occupancy plus head and second-slot payloads.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_EMPTY;
            head_r  <= {EW{1'b0}};
            tail_r  <= {EW{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        head_r  <= in_entry_s;
                        state_r <= ST_ONE;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && retire_s) begin
                        // Head leaves while the new entry takes its place.
                        head_r  <= in_entry_s;
                        state_r <= ST_ONE;
                    end else if (accept_s) begin
                        tail_r  <= in_entry_s;
                        state_r <= ST_FULL;
                    end else if (retire_s) begin
                        state_r <= ST_EMPTY;
                    end else begin
                        state_r <= ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (retire_s) begin
                        head_r  <= tail_r;
                        state_r <= ST_ONE;
                    end else begin
                        state_r <= ST_FULL;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    // Sticky flags, flag-check error and saturating retire counter; set beats clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sticky_zero_r <= 1'b0;
            sticky_neg_r  <= 1'b0;
            flag_err_r    <= 1'b0;
            count_r       <= {CNTW{1'b0}};
        end else begin
            sticky_zero_r <= (sticky_zero_r && !clr_sticky_i) || (retire_s && head_r[1]);
            sticky_neg_r  <= (sticky_neg_r && !clr_sticky_i) || (retire_s && head_r[0]);
            flag_err_r    <= (flag_err_r && !clr_sticky_i) ||
                             (accept_s && flag_mismatch(res_i, zero_i, neg_i));
            if (retire_s && (count_r != CNT_MAX)) begin
                count_r <= count_r + CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed self-checking bench for alu_wb_stage: main instance with default
// widths plus a CNTW=4 instance for counter saturation.
module tb_alu_wb_stage;

    localparam logic [1:0] SEL_ADD = 2'd0;
    localparam logic [1:0] SEL_SUB = 2'd1;
    localparam logic [1:0] SEL_AND = 2'd2;
    localparam logic [1:0] SEL_OR  = 2'd3;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel;
    logic [7:0]  res;
    logic        zero;
    logic        neg;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_sel;
    logic [7:0]  out_res;
    logic        out_zero;
    logic        out_neg;
    logic        sticky_zero;
    logic        sticky_neg;
    logic        flag_err;
    logic        clr_sticky;
    logic [15:0] count;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_res;
    logic        s_zero;
    logic        s_neg;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [1:0]  s_out_sel;
    logic [7:0]  s_out_res;
    logic        s_out_zero;
    logic        s_out_neg;
    logic        s_sticky_zero;
    logic        s_sticky_neg;
    logic        s_flag_err;
    logic [3:0]  s_count;

    int checks;
    int failures;

    alu_wb_stage #(.DWIDTH(8), .CNTW(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .sel_i(sel), .res_i(res), .zero_i(zero), .neg_i(neg),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_sel_o(out_sel), .out_res_o(out_res),
        .out_zero_o(out_zero), .out_neg_o(out_neg),
        .sticky_zero_o(sticky_zero), .sticky_neg_o(sticky_neg),
        .flag_err_o(flag_err), .clr_sticky_i(clr_sticky), .count_o(count)
    );

    alu_wb_stage #(.DWIDTH(8), .CNTW(4)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
        .sel_i(SEL_OR), .res_i(s_res), .zero_i(s_zero), .neg_i(s_neg),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
        .out_sel_o(s_out_sel), .out_res_o(s_out_res),
        .out_zero_o(s_out_zero), .out_neg_o(s_out_neg),
        .sticky_zero_o(s_sticky_zero), .sticky_neg_o(s_sticky_neg),
        .flag_err_o(s_flag_err), .clr_sticky_i(1'b0), .count_o(s_count)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 ns before driving/sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if ({out_sel, out_res, out_zero, out_neg} !== 12'h000) begin failures++; $display("FAIL reset_payload got=%h exp=000", {out_sel, out_res, out_zero, out_neg}); end
        checks++; if ({sticky_zero, sticky_neg, flag_err} !== 3'b000) begin failures++; $display("FAIL reset_sticky got=%b exp=000", {sticky_zero, sticky_neg, flag_err}); end
        checks++; if (count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; sel = SEL_ADD; res = 8'h05; zero = 1'b0; neg = 1'b0; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (out_res !== 8'h05) begin failures++; $display("FAIL basic_res got=%h exp=05", out_res); end
        checks++; if (out_sel !== SEL_ADD) begin failures++; $display("FAIL basic_sel got=%0d exp=0", out_sel); end
        checks++; if (count !== 16'd0) begin failures++; $display("FAIL basic_count_early got=%0d exp=0", count); end
        step();
        checks++; if (count !== 16'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
        checks++; if (flag_err !== 1'b0) begin failures++; $display("FAIL basic_flag_err got=%b exp=0", flag_err); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        in_valid = 1'b1; sel = SEL_SUB; res = 8'h10; zero = 1'b0; neg = 1'b0;
        step();
        sel = SEL_AND; res = 8'h20;
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", in_ready); end
        checks++; if (out_res !== 8'h10) begin failures++; $display("FAIL full_head got=%h exp=10", out_res); end
        // Third push is held off while full.
        sel = SEL_OR; res = 8'h30;
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_hold_ready got=%b exp=0", in_ready); end
        checks++; if (out_res !== 8'h10 || out_sel !== SEL_SUB) begin failures++; $display("FAIL full_hold_head got=%h/%0d exp=10/1", out_res, out_sel); end
        out_ready = 1'b1;
        step();
        checks++; if (out_res !== 8'h20 || out_sel !== SEL_AND) begin failures++; $display("FAIL full_second got=%h/%0d exp=20/2", out_res, out_sel); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_ready_back got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_res !== 8'h30 || out_valid !== 1'b1) begin failures++; $display("FAIL full_third got=%h v=%b exp=30 v=1", out_res, out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_empty got=%b exp=0", out_valid); end
        checks++; if (count !== 16'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; sel = SEL_ADD; res = 8'h11; zero = 1'b0; neg = 1'b0;
        step();
        res = 8'h22; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_res !== 8'h22 || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_head got=%h v=%b exp=22 v=1", out_res, out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_one_state got=%b exp=1", in_ready); end
        checks++; if (count !== 16'd5) begin failures++; $display("FAIL b2b_count got=%0d exp=5", count); end
        step();
        checks++; if (out_valid !== 1'b0 || count !== 16'd6) begin failures++; $display("FAIL b2b_drain got=v%b c%0d exp=v0 c6", out_valid, count); end
    endtask

    task automatic test_flags();
        out_ready = 1'b0;
        in_valid = 1'b1; res = 8'h00; zero = 1'b0; neg = 1'b0;
        step();
        checks++; if (flag_err !== 1'b1) begin failures++; $display("FAIL flag_err_set got=%b exp=1", flag_err); end
        res = 8'h80; zero = 1'b0; neg = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        checks++; if (out_res !== 8'h80 || out_neg !== 1'b1) begin failures++; $display("FAIL flag_fwd got=%h n=%b exp=80 n=1", out_res, out_neg); end
        step();
        checks++; if (sticky_neg !== 1'b1) begin failures++; $display("FAIL sticky_neg got=%b exp=1", sticky_neg); end
        checks++; if (sticky_zero !== 1'b0) begin failures++; $display("FAIL sticky_zero_clear got=%b exp=0", sticky_zero); end
        checks++; if (count !== 16'd8) begin failures++; $display("FAIL flags_count got=%0d exp=8", count); end
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        checks++; if ({sticky_zero, sticky_neg, flag_err} !== 3'b000) begin failures++; $display("FAIL clr_sticky got=%b exp=000", {sticky_zero, sticky_neg, flag_err}); end
        checks++; if (count !== 16'd8) begin failures++; $display("FAIL clr_keeps_count got=%0d exp=8", count); end
    endtask

    task automatic test_clr_vs_set();
        out_ready = 1'b0;
        in_valid = 1'b1; res = 8'h00; zero = 1'b1; neg = 1'b0;
        step();
        in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        checks++; if (sticky_zero !== 1'b1) begin failures++; $display("FAIL clr_set_wins got=%b exp=1", sticky_zero); end
        checks++; if (flag_err !== 1'b0) begin failures++; $display("FAIL clr_set_err got=%b exp=0", flag_err); end
        checks++; if (count !== 16'd9) begin failures++; $display("FAIL clr_set_count got=%0d exp=9", count); end
    endtask

    task automatic test_saturate();
        s_out_ready = 1'b1;
        s_in_valid = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            s_res = 8'(i); s_zero = 1'b0; s_neg = 1'b0;
            step();
        end
        s_in_valid = 1'b0;
        step();
        checks++; if (s_count !== 4'd15) begin failures++; $display("FAIL sat_count got=%0d exp=15", s_count); end
        checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL sat_drain got=%b exp=0", s_out_valid); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; res = 8'hA1; zero = 1'b0; neg = 1'b1;
        step();
        res = 8'hA2;
        step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL mid_full got=r%b v%b exp=r0 v1", in_ready, out_valid); end
        reset = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_ready_low got=%b exp=0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0 || count !== 16'd0) begin failures++; $display("FAIL mid_reset got=v%b c%0d exp=v0 c0", out_valid, count); end
        checks++; if (out_res !== 8'h00 || sticky_zero !== 1'b0) begin failures++; $display("FAIL mid_reset_regs got=%h z%b exp=00 z0", out_res, sticky_zero); end
        step();
        checks++; if (count !== 16'd0 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_hold got=c%0d r%b exp=c0 r0", count, in_ready); end
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_release got=%b exp=1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0 || count !== 16'd0) begin failures++; $display("FAIL mid_after got=v%b c%0d exp=v0 c0", out_valid, count); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; in_valid = 1'b0; sel = SEL_ADD; res = 8'h00; zero = 1'b0; neg = 1'b0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        s_in_valid = 1'b0; s_res = 8'h00; s_zero = 1'b0; s_neg = 1'b0; s_out_ready = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_flags();
        test_clr_vs_set();
        test_saturate();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
